// File: rtl/display_pkg.sv
// display_pkg
//   Shared definitions for the seven-segment display path timing blocks.
//   - clog2       : ceiling log2 for sizing counters and index buses
//   - scan_state_t: blank/active phase of a scan slot
//   - AN_POL_*    : anode polarity selectors for the AN_ACTIVE_LOW parameter
package display_pkg;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  typedef enum logic {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } scan_state_t;

  localparam int AN_POL_LOW  = 1;
  localparam int AN_POL_HIGH = 0;

endpackage

// File: rtl/tick_divider.sv
// tick_divider
//   Free-running modulo-DIV counter with synchronous clear.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     en       : count enable (holds when low)
//     clr      : synchronous clear, dominates en
//     div      : current count, 0..DIV-1
//     wrap     : high while div is at its last value (DIV-1)
module tick_divider
  import display_pkg::*;
#(
  parameter int DIV = 10,
  localparam int W = (clog2(DIV) < 1) ? 1 : clog2(DIV)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] div,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  assign wrap = (div == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (clr) begin
      div <= '0;
    end else if (en) begin
      div <= wrap ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// display_scanner
//   Multiplexed display scan controller. Splits time into DIV-cycle slots,
//   opens each slot with BLANK_CYCLES of dark time, then lights the anode of
//   the current digit. Masked-off digits are skipped when stepping.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     en         : scan enable; low parks the scanner dark with index held
//     digit_mask : 1 = digit takes part in the scan
//     digit_idx  : digit owning the current slot (segment data select)
//     anode      : registered anode drive, polarity per AN_ACTIVE_LOW
//     blank      : high while no anode is lit
//     scan_tick  : one-cycle pulse at each slot start
//     frame_tick : one-cycle pulse when the index wraps around
module display_scanner
  import display_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int SCAN_HZ       = 1000,
  parameter int DIGITS        = 4,
  parameter int BLANK_CYCLES  = 500,
  parameter int AN_ACTIVE_LOW = AN_POL_LOW,
  localparam int IDX_W = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIGITS-1:0] digit_mask,
  output logic [IDX_W-1:0]  digit_idx,
  output logic [DIGITS-1:0] anode,
  output logic              blank,
  output logic              scan_tick,
  output logic              frame_tick
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int DIV_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [DIV_W-1:0] BLANK_END =
    DIV_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  // XOR-ing the lit vector with the all-dark pattern yields the anode drive
  // for either polarity.
  localparam logic [DIGITS-1:0] ANODE_OFF =
    {DIGITS{(AN_ACTIVE_LOW == AN_POL_LOW)}};
  localparam logic [DIGITS-1:0] ONE = DIGITS'(1);

  if (DIV < 2 || DIV <= BLANK_CYCLES) begin : g_bad_div
    $error("display_scanner: DIV must be >= 2 and greater than BLANK_CYCLES");
  end
  if (DIGITS < 2) begin : g_bad_digits
    $error("display_scanner: DIGITS must be >= 2");
  end

  logic [DIV_W-1:0]  div;
  logic              wrap;
  scan_state_t       state;
  logic [IDX_W-1:0]  next_idx;
  logic [IDX_W-1:0]  cand;
  logic              found;
  logic              blank_done;
  logic [DIGITS-1:0] lit_cur;
  logic [DIGITS-1:0] lit_next;

  tick_divider #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (~en),
    .div  (div),
    .wrap (wrap)
  );

  // Circular search starting just after the current index; k == DIGITS
  // lands back on the current index so a lone enabled digit finds itself.
  always_comb begin
    found    = 1'b0;
    next_idx = digit_idx;
    cand     = '0;
    for (int k = 1; k <= DIGITS; k++) begin
      cand = IDX_W'((int'(digit_idx) + k) % DIGITS);
      if (!found && digit_mask[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  assign lit_cur    = (ONE << digit_idx) & digit_mask;
  assign lit_next   = (ONE << next_idx) & digit_mask;
  // After an enable gap the state is ST_BLANK even with no blanking, so the
  // zero-blank case leaves it on the first enabled edge.
  assign blank_done = (state == ST_BLANK) &&
                      ((BLANK_CYCLES == 0) || (div == BLANK_END));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      digit_idx  <= '0;
      anode      <= ANODE_OFF;
      blank      <= 1'b1;
      scan_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else if (!en) begin
      state      <= ST_BLANK;
      anode      <= ANODE_OFF;
      blank      <= 1'b1;
      scan_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else if (wrap) begin
      digit_idx  <= next_idx;
      scan_tick  <= 1'b1;
      frame_tick <= found && (next_idx <= digit_idx);
      if (BLANK_CYCLES == 0) begin
        state <= ST_ACTIVE;
        anode <= lit_next ^ ANODE_OFF;
        blank <= ~|lit_next;
      end else begin
        state <= ST_BLANK;
        anode <= ANODE_OFF;
        blank <= 1'b1;
      end
    end else begin
      scan_tick  <= 1'b0;
      frame_tick <= 1'b0;
      if (state == ST_ACTIVE || blank_done) begin
        // Live mask gating: a mid-slot mask change shows on the next edge.
        state <= ST_ACTIVE;
        anode <= lit_cur ^ ANODE_OFF;
        blank <= ~|lit_cur;
      end else begin
        anode <= ANODE_OFF;
        blank <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  localparam int CLK_HZ  = 100;
  localparam int SCAN_HZ = 10;
  localparam int DIGITS  = 4;
  localparam int BLANK   = 2;
  localparam int DIV     = CLK_HZ / SCAN_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] digit_mask = 4'hF;
  logic [1:0] digit_idx;
  logic [3:0] anode;
  logic       blank;
  logic       scan_tick;
  logic       frame_tick;

  always #5 clk = ~clk;

  display_scanner #(
    .CLK_HZ        (CLK_HZ),
    .SCAN_HZ       (SCAN_HZ),
    .DIGITS        (DIGITS),
    .BLANK_CYCLES  (BLANK),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_mask (digit_mask),
    .digit_idx  (digit_idx),
    .anode      (anode),
    .blank      (blank),
    .scan_tick  (scan_tick),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [3:0] anode;
    logic       blank;
    logic       st;
    logic       ft;
    logic [1:0] idx;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_pos    = 0;   // cycles elapsed in the current slot
  int   m_idx    = 0;   // digit owning the current slot

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_anode", {4'h0, anode}, 8'h0F);
    check("rst_blank", {7'h0, blank}, 8'h01);
    check("rst_scan_tick", {7'h0, scan_tick}, 8'h00);
    check("rst_frame_tick", {7'h0, frame_tick}, 8'h00);
    check("rst_idx", {6'h0, digit_idx}, 8'h00);
  endtask

  // Lowest enabled digit above cur, else lowest enabled overall; cur if none.
  function automatic int next_enabled(input int cur, input logic [3:0] m);
    for (int i = cur + 1; i < DIGITS; i++) if (m[i]) return i;
    for (int i = 0; i <= cur; i++) if (m[i]) return i;
    return cur;
  endfunction

  // Reference model: outputs expected after the coming clock edge.
  task automatic model_edge(input logic r, input logic e, input logic [3:0] m);
    exp_t x;
    int   old;
    logic lit;
    x   = '0;
    lit = 1'b0;
    if (r) begin
      m_pos = 0;
      m_idx = 0;
    end else if (!e) begin
      m_pos = 0;
    end else if (m_pos == DIV - 1) begin
      old   = m_idx;
      m_idx = next_enabled(old, m);
      m_pos = 0;
      x.st  = 1'b1;
      x.ft  = (m != 4'h0) && (m_idx <= old);
      lit   = (m_pos >= BLANK) && m[m_idx];
    end else begin
      m_pos = m_pos + 1;
      lit   = (m_pos >= BLANK) && m[m_idx];
    end
    x.anode = lit ? ~(4'b0001 << m_idx) : 4'hF;
    x.blank = ~lit;
    x.idx   = m_idx[1:0];
    q.push_back(x);
  endtask

  task automatic step(input logic e, input logic [3:0] m);
    @(negedge clk);
    rst        = 1'b0;
    en         = e;
    digit_mask = m;
    model_edge(1'b0, e, m);
  endtask

  // Monitor: compares every registered output cycle against the scoreboard.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("anode", {4'h0, anode}, {4'h0, x.anode});
        check("blank", {7'h0, blank}, {7'h0, x.blank});
        check("scan_tick", {7'h0, scan_tick}, {7'h0, x.st});
        check("frame_tick", {7'h0, frame_tick}, {7'h0, x.ft});
        check("digit_idx", {6'h0, digit_idx}, {6'h0, x.idx});
      end
    end
  end

  initial begin
    logic [3:0] m;
    logic       e;
    int         guard;

    #1 rst = 1'b1;
    #2 check_reset();
    m_pos = 0;
    m_idx = 0;

    // basic scan
    repeat (50) step(1'b1, 4'hF);
    // mask skip
    repeat (40) step(1'b1, 4'b0101);
    // all masked
    repeat (30) step(1'b1, 4'h0);

    // enable gap dropped at div==5
    guard = 0;
    do begin
      step(1'b1, 4'hF);
      guard++;
    end while (m_pos != 5 && guard < 3 * DIV);
    check("gap_align", 8'(m_pos), 8'd5);
    repeat (7) step(1'b0, 4'hF);
    repeat (30) step(1'b1, 4'hF);

    // async reset while a digit is lit
    guard = 0;
    do begin
      step(1'b1, 4'hF);
      guard++;
    end while (!(m_pos >= BLANK + 1 && m_pos < DIV - 1) && guard < 3 * DIV);
    check("lit_before_reset", {7'h0, blank}, 8'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    digit_mask = 4'b1000;
    #1 check_reset();
    model_edge(1'b1, 1'b1, 4'b1000);

    // single enabled digit from reset
    repeat (45) step(1'b1, 4'b1000);

    // randomized mask changes and enable drops
    m = 4'hF;
    repeat (600) begin
      e = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) m = 4'($urandom_range(0, 15));
      step(e, m);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Parametrised multiplexed-display scan controller. It divides the system clock into fixed scan slots and steps a digit index through `DIGITS` positions, skipping digits that are masked off. Each slot opens with a programmable blanking interval to suppress ghosting. It drives registered anode enables plus slot and frame strobes, and sits between the system clock and the segment/anode output stage of the seven-segment display path.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `SCAN_HZ`, default 1000: slot rate. `DIV = CLK_HZ/SCAN_HZ` cycles per slot. Elaboration error unless `DIV > BLANK_CYCLES` and `DIV >= 2`.
- `DIGITS`, default 4: digit count, must be ≥2. `IDX_W = clog2(DIGITS)`.
- `BLANK_CYCLES`, default 500: blank cycles at the start of each slot. 0 disables blanking.
- `AN_ACTIVE_LOW`, default 1: anode polarity. 1 means a lit digit is driven to 0.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  scan enable.
- `digit_mask`  in  DIGITS  1 = digit participates in the scan.
- `digit_idx`  out  IDX_W  index of the current slot's digit, used for segment data selection.
- `anode`  out  DIGITS  registered anode enables, polarity set by `AN_ACTIVE_LOW`.
- `blank`  out  1  high while no anode is lit.
- `scan_tick`  out  1  one-cycle pulse at each slot start.
- `frame_tick`  out  1  one-cycle pulse when the index wraps.

## Operation
- Divider `div` counts 0..DIV-1 while `en=1`.
- Two states:
  - `ST_BLANK`: all anodes inactive, `blank=1`.
  - `ST_ACTIVE`: `anode` = onehot(`digit_idx`) gated by `digit_mask`, in the set polarity.
- `ST_BLANK→ST_ACTIVE` on the edge where `div==BLANK_CYCLES-1`. If `BLANK_CYCLES=0`, each slot begins directly in `ST_ACTIVE`.
- Slot boundary (`div==DIV-1`) takes effect on the same edge:
  - `div←0`
  - state←`ST_BLANK` (or `ST_ACTIVE` if `BLANK_CYCLES=0`)
  - `digit_idx←next`
  - `scan_tick←1`
- `next` is the first index circularly after `digit_idx` whose mask bit is set. `digit_mask` is sampled on the boundary edge.
- `frame_tick←1` on the boundary edge when `next <= digit_idx`. With a single enabled digit, it therefore pulses every slot.
- All-zero mask:
  - `digit_idx` holds.
  - Anodes stay inactive and `blank=1`.
  - `scan_tick` continues; `frame_tick` never pulses.
- Mid-slot mask change: anode gating uses the live mask, so the anode turns off (or on) on the next edge. `digit_idx` changes only at a boundary.
- `en=0`:
  - Next edge: `div←0`, state←`ST_BLANK`, anodes inactive, ticks 0, `digit_idx` held.
  - On re-enable, a fresh slot starts for the held digit, with no `scan_tick` and no `frame_tick`.

## Timing
- Reset values (asynchronous, no clock edge needed):
  - `div=0`, `digit_idx=0`, state `ST_BLANK`
  - `anode` all inactive, `blank=1`
  - `scan_tick=0`, `frame_tick=0`
- After reset release:
  - The first slot uses index 0. If `digit_mask[0]=0`, that slot stays dark.
  - The first `scan_tick` arrives DIV cycles after release.
- All outputs are registered; there is no combinational input-to-output path.
- `scan_tick` is high during the cycle where `div==0` and coincides with the new `digit_idx`. `frame_tick` is high in that same cycle.
- Lit time per slot is `DIV-BLANK_CYCLES` cycles; frame period is DIV × (number of enabled digits).
- `digit_idx` wraps DIGITS-1 → lowest enabled index. When DIGITS is not a power of two, indices ≥DIGITS are never produced.

## Structure
- Shared package `display_pkg` holds:
  - the `clog2` function
  - the state enum (`ST_BLANK`, `ST_ACTIVE`)
  - the anode polarity constants
- Sub-module `tick_divider` (param `DIV`): synchronous counter with clear, outputs `div` and a `wrap` flag. It is reused by other display-path timing blocks.
- Next-enabled-index search and the blank/active FSM live in `display_scanner`.

## Test plan
All scenarios use `CLK_HZ=100`, `SCAN_HZ=10` (DIV=10), `BLANK_CYCLES=2`, `DIGITS=4`, `AN_ACTIVE_LOW=1`.
- Basic scan: `mask=4'b1111`, `en=1` → `digit_idx` steps 0,1,2,3,0 every 10 cycles. Each slot has 2 cycles `anode=4'b1111` with `blank=1`, then 8 cycles with one bit low. `frame_tick` pulses once per 40 cycles, on the 3→0 slot.
- Mask skip: `mask=4'b0101` → idx 0,2,0,2. `anode` active values 4'b1110 and 4'b1011; `frame_tick` every 20 cycles.
- All masked: `mask=0` → `anode=4'b1111` and `blank=1` constant, `scan_tick` every 10 cycles, `frame_tick` never.
- Enable gap: drop `en` at `div=5` for 7 cycles → anodes inactive from the next edge, idx held. After re-enable: 2 blank cycles, 8 lit cycles on the same idx, then the normal boundary.
- Async reset while lit → all outputs at reset values before the next clock edge. Scanning restarts at idx 0.
- Single digit: `mask=4'b1000` from reset → idx-0 slot dark with no `frame_tick`. Then idx 3 every slot with `anode=4'b0111` lit and `frame_tick` on every subsequent slot.
